mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory stage plus M/WB pipeline register, directly downstream of the EX/M latch.
- Turns the latched EX/M read and write enables into a data-cache request, holds the request until dhit, and raises mem_stall while the access is pending.
- Captures the load data and the writeback controls into the M/WB register on a pipeline advance.
- Flush zeroes the register as a bubble.

Parameters:
- WORD_W, 32, data and address width (word_t in cpu_types_pkg)
- REG_W, 5, register index width (regbits_t)

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  synchronous, active-low reset
- ihit  in  1  front-end advance strobe, shared with the other pipeline latches
- flush  in  1  load a bubble at the next advance
- dREN_in  in  1  load request, from the EX/M latch
- dWEN_in  in  1  store request, from the EX/M latch
- dmemStore_in  in  WORD_W  store data
- portO_in  in  WORD_W  ALU result, also the memory address
- LUI_in  in  WORD_W  LUI result
- MemtoReg_in  in  1  writeback select
- WSel_in  in  REG_W  destination register
- WEN_in  in  1  register write enable
- pcp4_in  in  WORD_W  PC+4
- dmemREN  out  1  cache read request
- dmemWEN  out  1  cache write request
- dmemaddr  out  WORD_W  {portO_in[31:2],2'b00}
- dmemstore  out  WORD_W  dmemStore_in
- dhit  in  1  cache access complete
- dmemload  in  WORD_W  cache read data, valid with dhit
- mem_stall  out  1  to hazard unit; freezes all upstream latches
- dmemload_wb, portO_wb, LUI_wb, pcp4_wb  out  WORD_W  M/WB register
- MemtoReg_wb, WEN_wb  out  1  M/WB register
- WSel_wb  out  REG_W  M/WB register

Behaviour:
- Clock and reset: all state updates on posedge CLK. nRST low at an edge clears every M/WB output to 0, clears the load-hold register and sets the state to IDLE. Reset overrides every other input, including an in-flight access; the cache is expected to be reset with the core.
- Access requested: req = dREN_in | dWEN_in.
- Illegal both-high case: if dREN_in and dWEN_in are both 1, the write wins. dmemWEN=1, dmemREN=0.
- FSM states: IDLE, ACCESS, DONE.
- Request outputs (combinational): dmemREN/dmemWEN are driven from the inputs only in IDLE (with req) and in ACCESS; they are 0 in DONE.
- Stall: mem_stall = (state!=DONE) & req & ~dhit.
- Advance: advance = ihit & ~mem_stall.
- IDLE transitions:
  - req & dhit: capture dmemload; stay IDLE if advance, else go to DONE.
  - req & ~dhit: go to ACCESS.
  - ~req: stay IDLE.
- ACCESS transitions:
  - Request held stable; mem_stall=1 until dhit.
  - On dhit, capture dmemload; go to IDLE if advance that cycle, else go to DONE.
- DONE transitions:
  - No request, mem_stall=0. This prevents a store from being issued twice while waiting for ihit.
  - On advance, go to IDLE.
- Load hold register: the captured dmemload is held until the M/WB register is loaded.
  - dmemload_wb receives the captured word, or live dmemload when dhit and advance coincide.
  - For a non-memory instruction, dmemload_wb receives 0.
- M/WB register:
  - Loads only on advance; otherwise every _wb output holds.
  - advance & flush: all _wb outputs load 0, so WEN_wb=0 (bubble).
  - advance & ~flush: the _wb outputs load the *_in values and the load data.
- Flush while in ACCESS: does not abort the access. The write completes, and the bubble is inserted at the advance.
- Stray dhit: dhit while ~req, or while in DONE, is ignored.
- Latency:
  - Non-memory instruction: 0 stall cycles.
  - Memory instruction: stall cycles = cycles until dhit; the _wb outputs are valid on the edge after the dhit-and-advance cycle.
- Upstream contract: the *_in inputs are stable while mem_stall=1 or the state is DONE, because the EX/M latch is frozen.

Decomposition:
- cpu_types_pkg: word_t, regbits_t, and a new mem_state_t enum {IDLE, ACCESS, DONE}.
- No sub-module; the FSM and register fit in one file.
- An interface mem_wb_if with modports for the stage and the writeback side is natural, matching the existing latch interfaces.

Test Plan:
- Reset: nRST=0 for 2 cycles with req=1 -> all _wb outputs 0, state IDLE; dmemREN follows dREN_in combinationally.
- Load with a 3-cycle miss: dREN_in=1, portO_in=0x0000_1003, dhit rising in cycle 3 with dmemload=0xDEADBEEF, ihit=1 -> dmemaddr=0x1000, mem_stall=1 for 2 cycles, then dmemload_wb=0xDEADBEEF and WSel_wb=WSel_in after the next edge.
- Store, dhit before ihit: dWEN_in=1, dhit in cycle 1, ihit arriving 4 cycles later -> dmemWEN high exactly 1 cycle, state DONE, no second write, register loads on the ihit edge.
- Same-cycle hit: dREN_in=1, dhit=1, ihit=1 in the same cycle -> mem_stall=0 and zero stall cycles; dmemload_wb takes live dmemload.
- Flush during ACCESS: store pending, flush=1 throughout -> write still completes; at advance all _wb outputs are 0 and WEN_wb=0.
- ALU instruction (req=0, WEN_in=1, portO_in=0x42, WSel_in=5) with ihit=1 -> mem_stall=0; after the next edge portO_wb=0x42, WEN_wb=1, WSel_wb=5, dmemload_wb=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types and the memory-stage state encoding.
package cpu_types_pkg;
  localparam int WORD_W = 32;
  localparam int REG_W = 5;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0] regbits_t;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;
endpackage

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-cache request sequencing plus the M/WB pipeline register.
module mem_wb_stage
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     ihit,
  input  logic     flush,
  input  logic     dREN_in,
  input  logic     dWEN_in,
  input  word_t    dmemStore_in,
  input  word_t    portO_in,
  input  word_t    LUI_in,
  input  logic     MemtoReg_in,
  input  regbits_t WSel_in,
  input  logic     WEN_in,
  input  word_t    pcp4_in,
  output logic     dmemREN,
  output logic     dmemWEN,
  output word_t    dmemaddr,
  output word_t    dmemstore,
  input  logic     dhit,
  input  word_t    dmemload,
  output logic     mem_stall,
  output word_t    dmemload_wb,
  output word_t    portO_wb,
  output word_t    LUI_wb,
  output word_t    pcp4_wb,
  output logic     MemtoReg_wb,
  output logic     WEN_wb,
  output regbits_t WSel_wb
);
  mem_state_t state, next;
  word_t load_q, load_d;
  logic req, live, advance;
  assign dmemaddr = {portO_in[WORD_W-1:2], 2'b00};
  assign dmemstore = dmemStore_in;
  // DONE means the access already completed; suppressing requests there keeps a store from repeating
  always_comb begin
    req = dREN_in | dWEN_in;
    live = state != DONE;
    dmemWEN = live & dWEN_in;
    dmemREN = live & dREN_in & ~dWEN_in;
    mem_stall = live & req & ~dhit;
    advance = ihit & ~mem_stall;
    load_d = ~req ? '0 : live ? dmemload : load_q;
    next = state;
    case (state)
      IDLE:    next = ~req ? IDLE : ~dhit ? ACCESS : advance ? IDLE : DONE;
      ACCESS:  next = ~dhit ? ACCESS : advance ? IDLE : DONE;
      default: next = advance ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      load_q <= '0;
      dmemload_wb <= '0;
      portO_wb <= '0;
      LUI_wb <= '0;
      pcp4_wb <= '0;
      MemtoReg_wb <= 1'b0;
      WEN_wb <= 1'b0;
      WSel_wb <= '0;
    end else begin
      state <= next;
      if (live & req & dhit) load_q <= dmemload;
      if (advance) begin
        dmemload_wb <= flush ? '0 : load_d;
        portO_wb <= flush ? '0 : portO_in;
        LUI_wb <= flush ? '0 : LUI_in;
        pcp4_wb <= flush ? '0 : pcp4_in;
        MemtoReg_wb <= ~flush & MemtoReg_in;
        WEN_wb <= ~flush & WEN_in;
        WSel_wb <= flush ? '0 : WSel_in;
      end
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized instruction stream checked against a per-transaction timing model.
module tb_mem_wb_stage;
  import cpu_types_pkg::*;
  logic CLK = 1'b0, nRST, ihit, flush, dREN_in, dWEN_in, MemtoReg_in, WEN_in;
  word_t dmemStore_in, portO_in, LUI_in, pcp4_in, dmemaddr, dmemstore, dmemload;
  regbits_t WSel_in, WSel_wb;
  logic dmemREN, dmemWEN, dhit, mem_stall, MemtoReg_wb, WEN_wb;
  word_t dmemload_wb, portO_wb, LUI_wb, pcp4_wb;
  word_t e_load, e_port, e_lui, e_pc;
  logic e_m2r, e_wen;
  regbits_t e_wsel;
  int checks = 0, errors = 0;
  mem_wb_stage dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .flush(flush), .dREN_in(dREN_in), .dWEN_in(dWEN_in),
    .dmemStore_in(dmemStore_in), .portO_in(portO_in), .LUI_in(LUI_in), .MemtoReg_in(MemtoReg_in),
    .WSel_in(WSel_in), .WEN_in(WEN_in), .pcp4_in(pcp4_in), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload), .mem_stall(mem_stall),
    .dmemload_wb(dmemload_wb), .portO_wb(portO_wb), .LUI_wb(LUI_wb), .pcp4_wb(pcp4_wb),
    .MemtoReg_wb(MemtoReg_wb), .WEN_wb(WEN_wb), .WSel_wb(WSel_wb)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_wb(input string tag);
    check({tag, ".load"}, dmemload_wb, e_load);
    check({tag, ".portO"}, portO_wb, e_port);
    check({tag, ".lui"}, LUI_wb, e_lui);
    check({tag, ".pcp4"}, pcp4_wb, e_pc);
    check({tag, ".m2r"}, 32'(MemtoReg_wb), 32'(e_m2r));
    check({tag, ".wen"}, 32'(WEN_wb), 32'(e_wen));
    check({tag, ".wsel"}, 32'(WSel_wb), 32'(e_wsel));
  endtask
  task automatic clear_model();
    {e_load, e_port, e_lui, e_pc, e_m2r, e_wen, e_wsel} = '0;
  endtask
  // kind: 0 ALU, 1 load, 2 store, 3 both enables (store wins); hc = dhit cycle, ic = first ihit cycle
  task automatic run(input int kind, input int hc, input int ic, input logic fl);
    word_t word;
    logic mem;
    int adv;
    word = $urandom;
    mem = kind != 0;
    dREN_in = kind == 1 || kind == 3;
    dWEN_in = kind >= 2;
    dmemStore_in = $urandom;
    portO_in = $urandom;
    LUI_in = $urandom;
    pcp4_in = $urandom;
    MemtoReg_in = 1'($urandom);
    WSel_in = 5'($urandom);
    WEN_in = 1'($urandom);
    flush = fl;
    adv = mem ? (hc > ic ? hc : ic) : ic;
    for (int c = 0; c <= adv; c++) begin
      dhit = mem && c == hc ? 1'b1 : (!mem || c > hc) ? 1'($urandom) : 1'b0;
      dmemload = (mem && c == hc) ? word : $urandom;
      ihit = c >= ic;
      @(negedge CLK);
      check("stall", 32'(mem_stall), 32'(mem && c < hc));
      check("dwen", 32'(dmemWEN), 32'(kind >= 2 && c <= hc));
      check("dren", 32'(dmemREN), 32'(kind == 1 && c <= hc));
      if (mem && c <= hc) begin
        check("addr", dmemaddr, portO_in & 32'hFFFF_FFFC);
        check("store", dmemstore, dmemStore_in);
      end
      check_wb("hold");
      @(posedge CLK);
      #1;
    end
    if (fl) clear_model();
    else begin
      e_load = mem ? word : 32'h0;
      e_port = portO_in;
      e_lui = LUI_in;
      e_pc = pcp4_in;
      e_m2r = MemtoReg_in;
      e_wen = WEN_in;
      e_wsel = WSel_in;
    end
    check_wb("wb");
    dhit = 1'b0;
    ihit = 1'b0;
  endtask
  task automatic do_reset();
    nRST = 1'b0;
    dREN_in = 1'b1;
    dWEN_in = 1'b0;
    dhit = 1'b0;
    ihit = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    clear_model();
    check_wb("rst");
    check("rst.dren", 32'(dmemREN), 32'd1);
    check("rst.stall", 32'(mem_stall), 32'd1);
    nRST = 1'b1;
    dREN_in = 1'b0;
    ihit = 1'b0;
  endtask
  initial begin
    {ihit, flush, dREN_in, dWEN_in, MemtoReg_in, WEN_in, dhit} = '0;
    {dmemStore_in, portO_in, LUI_in, pcp4_in, dmemload} = '0;
    WSel_in = '0;
    do_reset();
    run(1, 2, 0, 1'b0);
    run(2, 0, 4, 1'b0);
    run(1, 0, 0, 1'b0);
    run(2, 2, 0, 1'b1);
    run(0, 0, 0, 1'b0);
    run(3, 1, 3, 1'b0);
    run(1, 0, 2, 1'b0);
    for (int i = 0; i < 80; i++)
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), $urandom_range(0, 4) == 0);
    dREN_in = 1'b1;
    dWEN_in = 1'b0;
    ihit = 1'b1;
    @(posedge CLK);
    #1;
    do_reset();
    for (int i = 0; i < 20; i++)
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), $urandom_range(0, 4) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
